// File: rtl/spi_slave_pkg.sv
// Shared constants and types for the SPI slave front end: frame geometry,
// command codes, FSM state encoding and the MISO transmit phase.
package spi_slave_pkg;

  // Frame geometry.
  localparam int FRAME_W = 10;
  localparam int DATA_W  = 8;
  localparam int CNT_W   = 4;
  localparam int TX_CNT_W = 3;

  // Bit-counter landmarks, typed so comparisons stay width-exact.
  localparam logic [CNT_W-1:0]    CNT_LAST    = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0]    CNT_FULL    = CNT_W'(FRAME_W);
  localparam logic [TX_CNT_W-1:0] TX_CNT_LOAD = TX_CNT_W'(DATA_W - 1);

  // Command codes carried in rx_data[9:8]; decoded by the RAM, not here.
  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  // FSM state encoding.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_CHK_CMD   = 3'd1;
  localparam state_t ST_WRITE     = 3'd2;
  localparam state_t ST_READ_ADD  = 3'd3;
  localparam state_t ST_READ_DATA = 3'd4;

  // Progress of the read-data byte on MISO within one READ_DATA frame.
  typedef enum logic [1:0] {
    TX_WAIT,
    TX_SHIFT,
    TX_DONE
  } tx_phase_e;

  // Destination state chosen from the first frame bit. A leading 1 is a read;
  // whether it is the address or the data half depends on a pending address.
  function automatic state_t first_bit_state(input logic bit9, input logic seen);
    if (!bit9) begin
      return ST_WRITE;
    end else if (!seen) begin
      return ST_READ_ADD;
    end else begin
      return ST_READ_DATA;
    end
  endfunction

endpackage

// File: rtl/spi_rx_shifter.sv
// 10-bit serial-in/parallel-out register. Counts received bits, latches the
// completed word into a holding register and pulses done for one cycle.
// Bits beyond the frame width are ignored until the shifter is cleared.
module spi_rx_shifter
  import spi_slave_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               shift_en,
  input  logic               din,
  output logic [FRAME_W-1:0] word,
  output logic               done,
  output logic               last,
  output logic               full
);

  logic [FRAME_W-1:0] shreg;
  logic [CNT_W-1:0]   bit_cnt;

  // This edge samples the final bit of the frame.
  assign last = shift_en && !clr && (bit_cnt == CNT_LAST);
  // All frame bits have been received; later bits are dropped.
  assign full = (bit_cnt == CNT_FULL);

  // Shift MOSI in MSB first, count bits, publish the word on the last bit.
  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
      word    <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clr) begin
        shreg   <= '0;
        bit_cnt <= '0;
      end else if (shift_en && !full) begin
        shreg   <= {shreg[FRAME_W-2:0], din};
        bit_cnt <= bit_cnt + 1'b1;
        if (last) begin
          word <= {shreg[FRAME_W-2:0], din};
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/spi_slave.sv
// SPI slave front end for the single-port RAM. Deframes 10-bit command/data
// words from MOSI and, for a read-data frame, returns the RAM byte on MISO.
// The SPI clock is the system clock; inputs are sampled on rising edges.
module spi_slave
  import spi_slave_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               SS_n,
  input  logic               MOSI,
  output logic               MISO,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid,
  input  logic [DATA_W-1:0]  tx_data,
  input  logic               tx_valid
);

  state_t                state;
  state_t                state_nxt;
  logic                  rd_addr_seen;
  tx_phase_e             tx_phase;
  logic [DATA_W-1:0]     tx_shreg;
  logic [TX_CNT_W-1:0]   tx_cnt;

  logic                  rx_clr;
  logic                  rx_shift_en;
  logic                  rx_last;
  logic                  rx_full;
  logic                  in_read_data;
  logic                  tx_finish;

  // The receive shifter restarts whenever the frame is not active.
  assign rx_clr      = SS_n || (state == ST_IDLE);
  assign rx_shift_en = (state != ST_IDLE);

  // Read-data frame still selected this cycle.
  assign in_read_data = (state == ST_READ_DATA) && !SS_n;
  // Edge after the last data bit was presented on MISO.
  assign tx_finish    = in_read_data && (tx_phase == TX_SHIFT) && (tx_cnt == '0);

  spi_rx_shifter u_rx (
    .clk      (clk),
    .rst      (rst),
    .clr      (rx_clr),
    .shift_en (rx_shift_en),
    .din      (MOSI),
    .word     (rx_data),
    .done     (rx_valid),
    .last     (rx_last),
    .full     (rx_full)
  );

  // Next-state logic: the first frame bit picks write, read-address or read-data.
  // NOTE: the default assignment up front keeps this block free of latches.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (!SS_n) state_nxt = ST_CHK_CMD;
      ST_CHK_CMD:   state_nxt = SS_n ? ST_IDLE : first_bit_state(MOSI, rd_addr_seen);
      ST_WRITE,
      ST_READ_ADD,
      ST_READ_DATA: if (SS_n) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Pending read address: set by a completed READ_ADD frame, cleared once the
  // read byte has fully left on MISO. An aborted frame leaves it untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr_seen <= 1'b0;
    end else if ((state == ST_READ_ADD) && rx_last) begin
      rd_addr_seen <= 1'b1;
    end else if (tx_finish) begin
      rd_addr_seen <= 1'b0;
    end
  end

  // MISO serialiser: wait for RAM data after the frame, send 8 bits MSB first,
  // then hold MISO low and ignore further tx_valid until the frame ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_phase <= TX_WAIT;
      tx_shreg <= '0;
      tx_cnt   <= '0;
      MISO     <= 1'b0;
    end else if (!in_read_data) begin
      tx_phase <= TX_WAIT;
      tx_cnt   <= '0;
      MISO     <= 1'b0;
    end else begin
      case (tx_phase)
        TX_WAIT: begin
          if (rx_full && tx_valid) begin
            MISO     <= tx_data[DATA_W-1];
            tx_shreg <= {tx_data[DATA_W-2:0], 1'b0};
            tx_cnt   <= TX_CNT_LOAD;
            tx_phase <= TX_SHIFT;
          end
        end
        TX_SHIFT: begin
          if (tx_cnt == '0) begin
            MISO     <= 1'b0;
            tx_phase <= TX_DONE;
          end else begin
            MISO     <= tx_shreg[DATA_W-1];
            tx_shreg <= {tx_shreg[DATA_W-2:0], 1'b0};
            tx_cnt   <= tx_cnt - 1'b1;
          end
        end
        default: begin
          MISO <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a table of directed frames with fixed
// expectations, a hand-written mid-shift reset sequence, and randomized frames
// checked against a frame-level reference model.
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       rst;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  always #5 clk = ~clk;

  spi_slave dut (
    .clk      (clk),
    .rst      (rst),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference-model state: pending read address and the last published word.
  bit         m_seen;
  logic [9:0] m_rx_data;

  typedef struct {
    string      name;
    logic [9:0] word;
    int         len;      // edges with SS_n low, starting at edge k (j=0)
    int         tl;       // edge at which the RAM returns tx_valid (0: never)
    logic [7:0] tx_byte;
    bit         hold;     // hold tx_valid high on every edge
    int         exp_cnt;  // rx_valid strobes expected
    logic [9:0] exp_rx;
    logic [31:0] exp_vec; // bit j = MISO after edge j
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Drive one SS_n-framed transaction and record what the DUT did.
  // Inputs for edge j are set #1 after the previous edge; outputs are sampled #1
  // after edge j. Two SS_n-high edges follow the frame.
  task automatic run_frame(input logic [9:0] word, input int len, input int tl,
                           input logic [7:0] tx_byte, input bit hold, input bit spur,
                           input int rst_at, output int rxv_cnt, output int rxv_edge,
                           output logic [31:0] miso_vec);
    rxv_cnt  = 0;
    rxv_edge = -1;
    miso_vec = '0;
    for (int j = 0; j <= len + 1; j++) begin
      SS_n    = (j < len) ? 1'b0 : 1'b1;
      MOSI    = (j >= 1 && j <= 10) ? word[10-j] : 1'($urandom);
      tx_data = (j == tl) ? tx_byte : 8'($urandom);
      if (hold)                        tx_valid = 1'b1;
      else if (tl != 0 && j == tl)     tx_valid = 1'b1;
      else if (spur && (j <= 10 || j > tl)) tx_valid = 1'($urandom);
      else                             tx_valid = 1'b0;
      @(posedge clk);
      #1;
      if (rx_valid) begin
        rxv_cnt++;
        if (rxv_edge < 0) rxv_edge = j;
      end
      miso_vec[j] = MISO;
      if (j == rst_at) begin
        rst = 1'b1;
        #1;
        check("async_rst_miso",     32'(MISO),     32'd0);
        check("async_rst_rx_valid", 32'(rx_valid), 32'd0);
        check("async_rst_rx_data",  32'(rx_data),  32'd0);
        rst = 1'b0;
        break;
      end
    end
    SS_n     = 1'b1;
    tx_valid = 1'b0;
  endtask

  // Frame-level reference: a word is published only if SS_n stays low for the
  // 11 edges k..k+10; a read-data frame with a pending address sends the byte
  // on edges tl..tl+7 while SS_n is low and clears the address at tl+8.
  task automatic predict(input logic [9:0] word, input int len, input int tl,
                         input logic [7:0] tx_byte, output int e_cnt,
                         output int e_edge, output logic [31:0] e_vec);
    e_cnt  = 0;
    e_edge = -1;
    e_vec  = '0;
    if (len >= 11) begin
      e_cnt  = 1;
      e_edge = 10;
      if (word[9] && !m_seen) begin
        m_seen = 1'b1;
      end else if (word[9] && m_seen && tl != 0 && tl < len) begin
        for (int b = 0; b < 8; b++)
          if (tl + b < len) e_vec[tl+b] = tx_byte[7-b];
        if (tl + 8 < len) m_seen = 1'b0;
      end
      m_rx_data = word;
    end
  endtask

  task automatic model_frame(input string name, input logic [9:0] word, input int len,
                             input int tl, input logic [7:0] tx_byte, input bit spur);
    int          e_cnt, e_edge, o_cnt, o_edge;
    logic [31:0] e_vec, o_vec;
    predict(word, len, tl, tx_byte, e_cnt, e_edge, e_vec);
    run_frame(word, len, tl, tx_byte, 1'b0, spur, -1, o_cnt, o_edge, o_vec);
    check($sformatf("%s rx_valid_count w=%h len=%0d", name, word, len), 32'(o_cnt), 32'(e_cnt));
    check($sformatf("%s rx_valid_edge w=%h len=%0d", name, word, len), 32'(o_edge), 32'(e_edge));
    check($sformatf("%s rx_data w=%h len=%0d", name, word, len), 32'(rx_data), 32'(m_rx_data));
    check($sformatf("%s miso w=%h len=%0d tl=%0d", name, word, len, tl), o_vec, e_vec);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          o_cnt, o_edge, len, tl;
    logic [31:0] o_vec, e_vec;
    logic [9:0]  w;
    logic [7:0]  byt;
    logic [2:0]  pre_rst;
    int          e_cnt, e_edge;

    tbl[0] = '{"wr_addr",    10'h0A5, 12,  0, 8'h00, 1'b0, 1, 10'h0A5, 32'h0};
    tbl[1] = '{"wr_data",    10'h13C, 11,  0, 8'h00, 1'b0, 1, 10'h13C, 32'h0};
    tbl[2] = '{"rd_addr",    10'h207, 12,  0, 8'h00, 1'b0, 1, 10'h207, 32'h0};
    tbl[3] = '{"abort",      10'h3F0,  5,  0, 8'h00, 1'b0, 0, 10'h207, 32'h0};
    tbl[4] = '{"rd_data",    10'h355, 21, 12, 8'hC3, 1'b0, 1, 10'h355, 32'h000C3000};
    tbl[5] = '{"rd_noaddr",  10'h3C0, 21,  0, 8'hFF, 1'b1, 1, 10'h3C0, 32'h0};
    tbl[6] = '{"rd_data2",   10'h300, 22, 13, 8'hA5, 1'b0, 1, 10'h300, 32'h0014A000};
    tbl[7] = '{"extra_bits", 10'h0FF, 25,  0, 8'h00, 1'b0, 1, 10'h0FF, 32'h0};

    rst      = 1'b1;
    SS_n     = 1'b1;
    MOSI     = 1'b0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    m_seen   = 1'b0;
    m_rx_data = 10'h000;
    #1;
    check("reset MISO",     32'(MISO),     32'd0);
    check("reset rx_valid", 32'(rx_valid), 32'd0);
    check("reset rx_data",  32'(rx_data),  32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      predict(tbl[i].word, tbl[i].len, tbl[i].tl, tbl[i].tx_byte, e_cnt, e_edge, e_vec);
      run_frame(tbl[i].word, tbl[i].len, tbl[i].tl, tbl[i].tx_byte, tbl[i].hold, 1'b0,
                -1, o_cnt, o_edge, o_vec);
      check($sformatf("%s rx_valid_count", tbl[i].name), 32'(o_cnt), 32'(tbl[i].exp_cnt));
      if (tbl[i].exp_cnt > 0)
        check($sformatf("%s rx_valid_edge", tbl[i].name), 32'(o_edge), 32'd10);
      check($sformatf("%s rx_data", tbl[i].name), 32'(rx_data), 32'(tbl[i].exp_rx));
      check($sformatf("%s miso", tbl[i].name), o_vec, tbl[i].exp_vec);
    end

    // Reset during the MISO shift, then a read frame must be taken as an address.
    model_frame("pre_rst_addr", 10'h2F0, 11, 0, 8'h00, 1'b0);
    run_frame(10'h3FF, 25, 12, 8'hFF, 1'b0, 1'b0, 14, o_cnt, o_edge, o_vec);
    pre_rst = o_vec[14:12];
    check("miso high before reset", 32'(pre_rst), 32'h7);
    m_seen    = 1'b0;
    m_rx_data = 10'h000;
    model_frame("post_rst_read", 10'h3AB, 21, 12, 8'hFF, 1'b0);

    // Randomized frames against the reference model.
    for (int n = 0; n < 60; n++) begin
      w   = 10'($urandom);
      byt = 8'($urandom);
      tl  = $urandom_range(12, 14);
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 20) : $urandom_range(20, 25);
      model_frame("rand", w, len, tl, byt, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
